alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Hardwired sequencer for the 8-bit ALU system: fetches a 16-bit instruction in
// two byte cycles (T0/T1), decodes in T2 and finishes two-cycle ops in T3.
module alu_seq_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        FlagZ,
  output logic [3:0]  T,
  output logic        Halted,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_Enable,
  output logic        IR_LH,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_DEC = 4'h5;
  localparam logic [3:0] OP_BRA = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h7;
  localparam logic [3:0] OP_HLT = 4'h8;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_AND    = 4'b0111;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_IMM = 2'b10;

  localparam logic [3:0] REG_PC = 4'b1000;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  w_op;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic [3:0]  w_rd_onehot;
  logic        w_two_cycle;
  logic        w_unused_imm;

  assign w_op = IROut[15:12];
  assign w_rd = IROut[11:10];
  assign w_rs = IROut[9:8];

  // The immediate travels on the datapath via MuxA/MuxB, not through this block.
  assign w_unused_imm = ^IROut[7:0];

  always_comb begin
    w_rd_onehot = 4'b0000;
    case (w_rd)
      2'd0:    w_rd_onehot = 4'b1000;
      2'd1:    w_rd_onehot = 4'b0100;
      2'd2:    w_rd_onehot = 4'b0010;
      default: w_rd_onehot = 4'b0001;
    endcase
  end

  assign w_two_cycle = (w_op == OP_MOV) || (w_op == OP_ADD) || (w_op == OP_AND);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_T0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_T0:    w_next = S_T1;
      S_T1:    w_next = S_T2;
      S_T2: begin
        if (w_op == OP_HLT) begin
          w_next = S_HALT;
        end else if (w_two_cycle) begin
          w_next = S_T3;
        end else begin
          w_next = S_T0;
        end
      end
      S_T3:    w_next = S_T0;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_T0;
    endcase
  end

  // Every field starts idle; each state overrides only what it drives.
  always_comb begin
    T           = 4'b0000;
    Halted      = 1'b0;
    RF_OutASel  = 3'd0;
    RF_OutBSel  = 3'd0;
    RF_FunSel   = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'b00;
    ARF_OutDSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RegSel  = 4'b0000;
    IR_Enable   = 1'b0;
    IR_LH       = 1'b0;
    IR_Funsel   = 2'b00;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;

    if (!Reset) begin
      T = 4'b0001;
    end else begin
      case (r_state)
        S_T0, S_T1: begin
          T           = (r_state == S_T0) ? 4'b0001 : 4'b0010;
          Mem_CS      = 1'b0;
          Mem_WR      = 1'b0;
          ARF_OutDSel = 2'b00;
          IR_Enable   = 1'b1;
          IR_LH       = (r_state == S_T1);
          IR_Funsel   = FUN_LOAD;
          ARF_RegSel  = REG_PC;
          ARF_FunSel  = FUN_INC;
        end
        S_T2: begin
          T = 4'b0100;
          case (w_op)
            OP_LDI: begin
              MuxASel   = MUX_IMM;
              RF_FunSel = FUN_LOAD;
              RF_RSel   = w_rd_onehot;
            end
            OP_MOV: begin
              RF_OutASel = {1'b0, w_rs};
              MuxCSel    = 1'b0;
              ALU_FunSel = ALU_PASS_A;
            end
            OP_ADD, OP_AND: begin
              RF_OutASel = {1'b0, w_rd};
              RF_OutBSel = {1'b0, w_rs};
              ALU_FunSel = (w_op == OP_ADD) ? ALU_ADD : ALU_AND;
            end
            OP_INC, OP_DEC: begin
              RF_FunSel = (w_op == OP_INC) ? FUN_INC : FUN_DEC;
              RF_RSel   = w_rd_onehot;
            end
            OP_BRA, OP_BEQ: begin
              // BEQ with a clear zero flag falls through with no write at all.
              if ((w_op == OP_BRA) || FlagZ) begin
                MuxBSel    = MUX_IMM;
                ARF_FunSel = FUN_LOAD;
                ARF_RegSel = REG_PC;
              end
            end
            default: begin
            end
          endcase
        end
        S_T3: begin
          T = 4'b1000;
          if (w_two_cycle) begin
            MuxASel   = MUX_ALU;
            RF_FunSel = FUN_LOAD;
            RF_RSel   = w_rd_onehot;
          end
        end
        S_HALT: begin
          Halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: per-cycle expected control words are queued as each
// instruction is driven and compared mid-cycle against the DUT outputs.
module tb_alu_seq_ctrl;

  typedef struct packed {
    logic [3:0] t;
    logic       halted;
    logic [2:0] outa;
    logic [2:0] outb;
    logic [1:0] rf_fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [3:0] alu_fun;
    logic [1:0] outc;
    logic [1:0] outd;
    logic [1:0] arf_fun;
    logic [3:0] regsel;
    logic       ir_en;
    logic       ir_lh;
    logic [1:0] ir_fun;
    logic       mem_cs;
    logic       mem_wr;
    logic [1:0] muxa;
    logic [1:0] muxb;
    logic       muxc;
  } ctl_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic        FlagZ;
  logic [3:0]  T;
  logic        Halted;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_Enable, IR_LH;
  logic [1:0]  IR_Funsel;
  logic        Mem_CS, Mem_WR;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;

  ctl_t obs;
  ctl_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 Clock = ~Clock;

  alu_seq_ctrl dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagZ(FlagZ),
    .T(T), .Halted(Halted),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_Enable(IR_Enable), .IR_LH(IR_LH), .IR_Funsel(IR_Funsel),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel)
  );

  assign obs = {T, Halted, RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel,
                ALU_FunSel, ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
                IR_Enable, IR_LH, IR_Funsel, Mem_CS, Mem_WR, MuxASel, MuxBSel, MuxCSel};

  // ---------------- expected-word builders ----------------
  function automatic ctl_t f_idle(input logic [3:0] t);
    ctl_t c;
    c = '0;
    c.t = t;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_fetch(input logic lh);
    ctl_t c;
    c = f_idle(lh ? 4'b0010 : 4'b0001);
    c.mem_cs  = 1'b0;
    c.ir_en   = 1'b1;
    c.ir_lh   = lh;
    c.ir_fun  = 2'b10;
    c.regsel  = 4'b1000;
    c.arf_fun = 2'b01;
    return c;
  endfunction

  function automatic logic [3:0] f_rsel(input logic [1:0] rd);
    case (rd)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b0100;
      2'd2:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic ctl_t f_halt();
    ctl_t c;
    c = f_idle(4'b0000);
    c.halted = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_ldi_t2(input logic [1:0] rd);
    ctl_t c;
    c = f_idle(4'b0100);
    c.muxa = 2'b10;
    c.rf_fun = 2'b10;
    c.rsel = f_rsel(rd);
    return c;
  endfunction

  function automatic ctl_t f_wb_t3(input logic [1:0] rd);
    ctl_t c;
    c = f_idle(4'b1000);
    c.muxa = 2'b00;
    c.rf_fun = 2'b10;
    c.rsel = f_rsel(rd);
    return c;
  endfunction

  function automatic ctl_t f_pc_load_t2();
    ctl_t c;
    c = f_idle(4'b0100);
    c.muxb = 2'b10;
    c.arf_fun = 2'b10;
    c.regsel = 4'b1000;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_fetch();
    exp_q.push_back(f_fetch(1'b0));
    exp_q.push_back(f_fetch(1'b1));
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ctl_t want;
    Reset = 1'b0;
    IROut = 16'h0000;
    FlagZ = 1'b0;
    exp_q.push_back(f_idle(4'b0001));
    exp_q.push_back(f_idle(4'b0001));
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL reset t=%0t: got %h want %h", $time, obs, want);
      end
      next_cycle();
    end
    Reset = 1'b1;
  endtask

  task automatic test_ldi();
    ctl_t want;
    IROut = 16'h002A;
    push_fetch();
    exp_q.push_back(f_ldi_t2(2'd0));
    exp_q.push_back(f_fetch(1'b0));
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL ldi t=%0t: got %h want %h", $time, obs, want);
      end
      next_cycle();
      if (exp_q.size() == 1) IROut = 16'h0000;
    end
    // The trailing T0 above already began the next instruction (LDI R1,0); finish it.
    exp_q.push_back(f_fetch(1'b1));
    exp_q.push_back(f_ldi_t2(2'd0));
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL ldi_tail t=%0t: got %h want %h", $time, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_two_cycle();
    ctl_t want;
    ctl_t t2;
    logic [15:0] irs [3];
    irs[0] = 16'h2600;  // ADD R2,R3
    irs[1] = 16'h1D00;  // MOV R4,R2
    irs[2] = 16'h3300;  // AND R1,R4
    for (int k = 0; k < 3; k++) begin
      IROut = irs[k];
      t2 = f_idle(4'b0100);
      case (k)
        0: begin t2.outa = 3'd1; t2.outb = 3'd2; t2.alu_fun = 4'b0100; end
        1: begin t2.outa = 3'd1; t2.alu_fun = 4'b0000; end
        default: begin t2.outa = 3'd0; t2.outb = 3'd3; t2.alu_fun = 4'b0111; end
      endcase
      push_fetch();
      exp_q.push_back(t2);
      exp_q.push_back(f_wb_t3(irs[k][11:10]));
      while (exp_q.size() > 0) begin
        @(negedge Clock);
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
          miscompares++;
          $display("FAIL two_cycle[%0d] t=%0t: got %h want %h", k, $time, obs, want);
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_inc_dec_branch();
    ctl_t want;
    ctl_t t2;
    logic [15:0] irs [5];
    logic        zs  [5];
    irs[0] = 16'h4800; zs[0] = 1'b0;  // INC R3
    irs[1] = 16'h5400; zs[1] = 1'b1;  // DEC R2
    irs[2] = 16'h7010; zs[2] = 1'b0;  // BEQ 0x10, not taken
    irs[3] = 16'h7010; zs[3] = 1'b1;  // BEQ 0x10, taken
    irs[4] = 16'h6055; zs[4] = 1'b0;  // BRA 0x55
    for (int k = 0; k < 5; k++) begin
      IROut = irs[k];
      FlagZ = zs[k];
      t2 = f_idle(4'b0100);
      case (k)
        0: begin t2.rf_fun = 2'b01; t2.rsel = 4'b0010; end
        1: begin t2.rf_fun = 2'b00; t2.rsel = 4'b0100; end
        2: t2 = f_idle(4'b0100);
        default: t2 = f_pc_load_t2();
      endcase
      push_fetch();
      exp_q.push_back(t2);
      while (exp_q.size() > 0) begin
        @(negedge Clock);
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
          miscompares++;
          $display("FAIL inc_dec_branch[%0d] t=%0t: got %h want %h", k, $time, obs, want);
        end
        next_cycle();
      end
    end
    FlagZ = 1'b0;
  endtask

  task automatic test_random_ldi_nop();
    ctl_t want;
    logic [15:0] ir;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        ir = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
        exp_q.push_back(f_fetch(1'b0));
        exp_q.push_back(f_fetch(1'b1));
        exp_q.push_back(f_ldi_t2(ir[11:10]));
      end else begin
        ir = {4'($urandom_range(9, 15)), 12'($urandom_range(0, 4095))};
        exp_q.push_back(f_fetch(1'b0));
        exp_q.push_back(f_fetch(1'b1));
        exp_q.push_back(f_idle(4'b0100));
      end
      IROut = ir;
      FlagZ = 1'($urandom_range(0, 1));
      while (exp_q.size() > 0) begin
        @(negedge Clock);
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
          miscompares++;
          $display("FAIL rand_ldi_nop[%0d] ir=%h t=%0t: got %h want %h", k, ir, $time, obs, want);
        end
        next_cycle();
      end
    end
    FlagZ = 1'b0;
  endtask

  task automatic test_reset_mid();
    ctl_t want;
    IROut = 16'h2600;
    push_fetch();
    begin
      ctl_t t2;
      t2 = f_idle(4'b0100);
      t2.outa = 3'd1; t2.outb = 3'd2; t2.alu_fun = 4'b0100;
      exp_q.push_back(t2);
    end
    exp_q.push_back(f_idle(4'b0001));  // T3 slot, squashed by reset
    push_fetch();
    exp_q.push_back(f_idle(4'b0100));  // NOP 0xC in T2
    exp_q.push_back(f_fetch(1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i == 3) Reset = 1'b0;
      if (i == 4) begin
        Reset = 1'b1;
        IROut = 16'hC123;
      end
      @(negedge Clock);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL reset_mid cyc=%0d t=%0t: got %h want %h", i, $time, obs, want);
      end
      next_cycle();
    end
    // Close out the instruction whose T0 was just checked.
    IROut = 16'h9000;
    exp_q.push_back(f_fetch(1'b1));
    exp_q.push_back(f_idle(4'b0100));
    while (exp_q.size() > 0) begin
      @(negedge Clock);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL reset_mid_tail t=%0t: got %h want %h", $time, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_halt();
    ctl_t want;
    IROut = 16'h8000;
    push_fetch();
    exp_q.push_back(f_idle(4'b0100));
    for (int i = 0; i < 10; i++) exp_q.push_back(f_halt());
    exp_q.push_back(f_idle(4'b0001));  // one reset cycle
    exp_q.push_back(f_fetch(1'b0));
    exp_q.push_back(f_fetch(1'b1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      if (i >= 3 && i < 13) begin
        IROut = 16'($urandom_range(0, 65535));
        FlagZ = 1'($urandom_range(0, 1));
      end
      if (i == 13) Reset = 1'b0;
      if (i == 14) Reset = 1'b1;
      @(negedge Clock);
      want = exp_q.pop_front();
      vectors++;
      if (obs !== want) begin
        miscompares++;
        $display("FAIL halt cyc=%0d t=%0t: got %h want %h", i, $time, obs, want);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_two_cycle();
    test_inc_dec_branch();
    test_random_ldi_nop();
    test_reset_mid();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
